debug_cmd_engine: RTL and testbench
===================================

Name: debug_cmd_engine

Overview:
- Parametrised next-generation debug command engine. Decodes a byte stream from the UART receiver into memory read, write and fill operations across multiple memory spaces (e.g. CPU bus, PPU bus).
- Streams response bytes to the UART transmitter under a valid/ready handshake.
- Sits between the UART RX/TX modules and the debug memory-access mux.

Parameters:
ADDR_WIDTH, 16, memory address width; must be a multiple of 8, range 8..32
LEN_WIDTH, 16, transfer length width; must be a multiple of 8, range 8..32
SPACE_WIDTH, 2, memory space select width (max 4)
MEM_READ_LATENCY, 1, cycles from o_mem_en (read) to valid i_mem_data; range 1..4

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous, active-low reset
i_rx_dv  in  1  one-cycle pulse, i_rx_byte valid
i_rx_byte  in  8  received byte
o_tx_dv  out  1  tx byte valid; held until accepted
o_tx_byte  out  8  tx byte; 0 when o_tx_dv=0
i_tx_ready  in  1  transmitter accepts byte in cycles where o_tx_dv & i_tx_ready
o_mem_en  out  1  one-cycle access strobe
o_mem_rw  out  1  1=read, 0=write
o_mem_space  out  SPACE_WIDTH  space of current access
o_mem_address  out  ADDR_WIDTH  access address; 0 when o_mem_en=0
o_mem_data  out  8  write data; 0 unless o_mem_en & ~o_mem_rw
i_mem_data  in  8  read data
o_cmd  out  8  current command byte; 0 when idle
o_bytes_remaining  out  LEN_WIDTH  data bytes left in current transfer
o_busy  out  1  1 whenever state != IDLE
o_rx_overflow  out  1  one-cycle pulse: rx byte dropped

Behaviour:
- Reset: all outputs 0 except o_mem_rw=1; state IDLE. Reset mid-command aborts with no further memory access or tx.
- Command byte: [3:0] opcode, [SPACE_WIDTH+3:4] space; other bits ignored.
- Opcodes:
  - 0 NOP.
  - 1 ECHO: 1 arg byte, returned on tx.
  - 2 WRITE, 3 READ, 4 FILL: header = ADDR_WIDTH/8 address bytes then LEN_WIDTH/8 length bytes, both MSB first.
  - 5 INFO: tx ADDR_WIDTH, then LEN_WIDTH.
  - Others: treated as NOP.
- States: IDLE, ECHO_ARG, HDR, WR_DATA, FILL_VAL, FILL_RUN, RD_ISSUE, RD_WAIT, TX_WAIT.
- IDLE + rx:
  - latch o_cmd;
  - opcode 1 -> ECHO_ARG;
  - opcode 2/3/4 -> HDR;
  - opcode 5 -> TX_WAIT (two bytes);
  - else stay IDLE, o_cmd back to 0 next cycle.
- HDR: shift bytes into address, then length. After the last header byte:
  - length 0 -> IDLE (no access).
  - Else WRITE -> WR_DATA, READ -> RD_ISSUE, FILL -> FILL_VAL.
- WR_DATA: each rx byte produces o_mem_en=1, rw=0, data=byte in the following cycle. Address then increments and remaining decrements. At remaining 0 -> IDLE.
- FILL_VAL: rx value byte -> FILL_RUN. FILL_RUN writes the value once per cycle, back-to-back, for length cycles, then -> IDLE.
- RD_ISSUE: o_mem_en=1, rw=1 for one cycle -> RD_WAIT.
- RD_WAIT: after MEM_READ_LATENCY cycles, capture i_mem_data into o_tx_byte, assert o_tx_dv -> TX_WAIT.
- TX_WAIT: hold byte until accepted. Then:
  - READ: address+1, remaining-1; -> RD_ISSUE if remaining>0, else IDLE.
  - ECHO: -> IDLE.
  - INFO: second byte follows, then IDLE.
- Address wraps modulo 2^ADDR_WIDTH; no carry into space.
- o_bytes_remaining = loaded length minus completed data bytes.
- rx byte arriving in FILL_RUN, RD_*, TX_WAIT: dropped, o_rx_overflow pulses; state unaffected.
- o_tx_dv never deasserts before acceptance; o_tx_byte stable while o_tx_dv=1.

Test Plan:
- ECHO: rx 0x01,0x5A with i_tx_ready=1 -> single tx 0x5A, o_busy returns to 0, o_cmd=0.
- WRITE: rx 0x12,0x02,0x00,0x00,0x03,AA,BB,CC -> three writes, space 1, to 0x0200/0201/0202 with data AA/BB/CC; one o_mem_en pulse each.
- READ with backpressure: memory preloaded 0x10..0x13 at 0xFFFE..0x0001, rx 0x03,FF,FE,00,04, i_tx_ready low 5 cycles per byte -> tx 0x10,0x11,0x12,0x13; address wraps to 0x0000; no duplicated or lost bytes.
- FILL: rx 0x04,0x00,0x10,0x00,0x05,0xEE -> 5 consecutive-cycle writes of 0xEE to 0x0010..0x0014; rx byte injected mid-run -> o_rx_overflow pulse, fill unaffected.
- Zero length and unknown opcode: READ with length 0 -> no o_mem_en, no tx; rx 0x0F -> ignored, next ECHO works normally.
- Reset mid-READ (after 2 of 4 bytes): all outputs at reset values, o_mem_rw=1; subsequent INFO returns 0x10,0x10.

Source files
------------

// File: rtl/debug_cmd_if.sv
// Byte-stream, transmit and memory-access signals between the debug command
// engine (slave side) and the UART / memory-mux environment (master side).
interface debug_cmd_if #(
   parameter int ADDR_WIDTH  = 16,
   parameter int SPACE_WIDTH = 2
);
   logic                   i_rx_dv;
   logic [7:0]             i_rx_byte;
   logic                   o_tx_dv;
   logic [7:0]             o_tx_byte;
   logic                   i_tx_ready;
   logic                   o_mem_en;
   logic                   o_mem_rw;
   logic [SPACE_WIDTH-1:0] o_mem_space;
   logic [ADDR_WIDTH-1:0]  o_mem_address;
   logic [7:0]             o_mem_data;
   logic [7:0]             i_mem_data;

   modport slave (
      input  i_rx_dv, i_rx_byte, i_tx_ready, i_mem_data,
      output o_tx_dv, o_tx_byte, o_mem_en, o_mem_rw, o_mem_space,
             o_mem_address, o_mem_data
   );

   modport master (
      output i_rx_dv, i_rx_byte, i_tx_ready, i_mem_data,
      input  o_tx_dv, o_tx_byte, o_mem_en, o_mem_rw, o_mem_space,
             o_mem_address, o_mem_data
   );
endinterface

// File: rtl/debug_cmd_engine.sv
// Debug command engine: turns UART rx bytes into memory read/write/fill
// accesses over several memory spaces and streams responses to the UART tx.
module debug_cmd_engine #(
   parameter int ADDR_WIDTH       = 16,
   parameter int LEN_WIDTH        = 16,
   parameter int SPACE_WIDTH      = 2,
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   debug_cmd_if.slave           bus,
   output logic [7:0]           o_cmd,
   output logic [LEN_WIDTH-1:0] o_bytes_remaining,
   output logic                 o_busy,
   output logic                 o_rx_overflow
);
   localparam logic [3:0] ADDR_BYTES = 4'(ADDR_WIDTH / 8);
   localparam logic [3:0] HDR_LAST   = 4'((ADDR_WIDTH + LEN_WIDTH) / 8 - 1);
   localparam logic [2:0] RD_LAT     = 3'(MEM_READ_LATENCY);

   localparam logic [3:0] OP_ECHO  = 4'd1;
   localparam logic [3:0] OP_WRITE = 4'd2;
   localparam logic [3:0] OP_READ  = 4'd3;
   localparam logic [3:0] OP_FILL  = 4'd4;
   localparam logic [3:0] OP_INFO  = 4'd5;

   typedef enum logic [3:0] {
      IDLE, ECHO_ARG, HDR, WR_DATA, FILL_VAL, FILL_RUN, RD_ISSUE, RD_WAIT, TX_WAIT
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [SPACE_WIDTH-1:0] space_q, space_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [3:0]             hdr_cnt_q, hdr_cnt_d;
   logic [7:0]             fill_val_q, fill_val_d;
   logic [2:0]             rd_cnt_q, rd_cnt_d;
   logic                   info_pend_q, info_pend_d;
   logic                   tx_dv_q, tx_dv_d;
   logic [7:0]             tx_byte_q, tx_byte_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_rw_q, mem_rw_d;
   logic [SPACE_WIDTH-1:0] mem_space_q, mem_space_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [7:0]             mem_wdata_q, mem_wdata_d;
   logic                   ovf_q, ovf_d;
   logic                   tx_accept;

   assign tx_accept = tx_dv_q & bus.i_tx_ready;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         space_q     <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         hdr_cnt_q   <= '0;
         fill_val_q  <= '0;
         rd_cnt_q    <= '0;
         info_pend_q <= 1'b0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b1;
         mem_space_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         space_q     <= space_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         hdr_cnt_q   <= hdr_cnt_d;
         fill_val_q  <= fill_val_d;
         rd_cnt_q    <= rd_cnt_d;
         info_pend_q <= info_pend_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_space_q <= mem_space_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      space_d     = space_q;
      addr_d      = addr_q;
      len_d       = len_q;
      hdr_cnt_d   = hdr_cnt_q;
      fill_val_d  = fill_val_q;
      rd_cnt_d    = rd_cnt_q;
      info_pend_d = info_pend_q;
      tx_dv_d     = tx_dv_q;
      tx_byte_d   = tx_byte_q;
      mem_en_d    = 1'b0;
      mem_rw_d    = 1'b1;
      mem_space_d = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      ovf_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.i_rx_dv) begin
               cmd_d     = bus.i_rx_byte;
               space_d   = bus.i_rx_byte[SPACE_WIDTH+3:4];
               addr_d    = '0;
               len_d     = '0;
               hdr_cnt_d = '0;
               case (bus.i_rx_byte[3:0])
                  OP_ECHO:                   state_d = ECHO_ARG;
                  OP_WRITE, OP_READ, OP_FILL: state_d = HDR;
                  OP_INFO: begin
                     state_d     = TX_WAIT;
                     tx_dv_d     = 1'b1;
                     tx_byte_d   = 8'(ADDR_WIDTH);
                     info_pend_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ECHO_ARG: begin
            if (bus.i_rx_dv) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = bus.i_rx_byte;
               state_d   = TX_WAIT;
            end
         end
         HDR: begin
            // address bytes arrive first, then length, both MSB first
            if (bus.i_rx_dv) begin
               hdr_cnt_d = hdr_cnt_q + 4'd1;
               if (hdr_cnt_q < ADDR_BYTES) addr_d = ADDR_WIDTH'({addr_q, bus.i_rx_byte});
               else                        len_d  = LEN_WIDTH'({len_q, bus.i_rx_byte});
               if (hdr_cnt_q == HDR_LAST) begin
                  if (len_d == '0)                state_d = IDLE;
                  else if (cmd_q[3:0] == OP_WRITE) state_d = WR_DATA;
                  else if (cmd_q[3:0] == OP_READ)  state_d = RD_ISSUE;
                  else                             state_d = FILL_VAL;
               end
            end
         end
         WR_DATA: begin
            if (bus.i_rx_dv) begin
               mem_en_d    = 1'b1;
               mem_rw_d    = 1'b0;
               mem_space_d = space_q;
               mem_addr_d  = addr_q;
               mem_wdata_d = bus.i_rx_byte;
               addr_d      = addr_q + ADDR_WIDTH'(1);
               len_d       = len_q - LEN_WIDTH'(1);
               if (len_q == LEN_WIDTH'(1)) state_d = IDLE;
            end
         end
         FILL_VAL: begin
            if (bus.i_rx_dv) begin
               fill_val_d = bus.i_rx_byte;
               state_d    = FILL_RUN;
            end
         end
         FILL_RUN: begin
            ovf_d       = bus.i_rx_dv;
            mem_en_d    = 1'b1;
            mem_rw_d    = 1'b0;
            mem_space_d = space_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = fill_val_q;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            len_d       = len_q - LEN_WIDTH'(1);
            if (len_q == LEN_WIDTH'(1)) state_d = IDLE;
         end
         RD_ISSUE: begin
            ovf_d       = bus.i_rx_dv;
            mem_en_d    = 1'b1;
            mem_space_d = space_q;
            mem_addr_d  = addr_q;
            rd_cnt_d    = '0;
            state_d     = RD_WAIT;
         end
         RD_WAIT: begin
            // strobe is registered, so data is valid RD_LAT cycles into this state
            ovf_d = bus.i_rx_dv;
            if (rd_cnt_q == RD_LAT) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = bus.i_mem_data;
               state_d   = TX_WAIT;
            end else begin
               rd_cnt_d = rd_cnt_q + 3'd1;
            end
         end
         TX_WAIT: begin
            ovf_d = bus.i_rx_dv;
            if (tx_accept) begin
               if (info_pend_q) begin
                  tx_byte_d   = 8'(LEN_WIDTH);
                  info_pend_d = 1'b0;
               end else begin
                  tx_dv_d   = 1'b0;
                  tx_byte_d = '0;
                  if (cmd_q[3:0] == OP_READ) begin
                     addr_d  = addr_q + ADDR_WIDTH'(1);
                     len_d   = len_q - LEN_WIDTH'(1);
                     state_d = (len_q == LEN_WIDTH'(1)) ? IDLE : RD_ISSUE;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // o_cmd reads 0 whenever idle; a NOP keeps it for its single cycle only
      if (state_d == IDLE && !(state_q == IDLE && bus.i_rx_dv)) cmd_d = '0;
   end

   assign bus.o_tx_dv       = tx_dv_q;
   assign bus.o_tx_byte     = tx_byte_q;
   assign bus.o_mem_en      = mem_en_q;
   assign bus.o_mem_rw      = mem_rw_q;
   assign bus.o_mem_space   = mem_space_q;
   assign bus.o_mem_address = mem_addr_q;
   assign bus.o_mem_data    = mem_wdata_q;
   assign o_cmd             = cmd_q;
   assign o_bytes_remaining = len_q;
   assign o_busy            = (state_q != IDLE);
   assign o_rx_overflow     = ovf_q;
endmodule

// File: tb/tb_debug_cmd_engine.sv
// Bench for debug_cmd_engine: vector table, corner-case sequences and random
// commands checked against a command-level reference model.
module tb_debug_cmd_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  o_cmd;
   logic [15:0] o_bytes_remaining;
   logic        o_busy;
   logic        o_rx_overflow;

   debug_cmd_if #(.ADDR_WIDTH(16), .SPACE_WIDTH(2)) bus ();

   debug_cmd_engine #(.ADDR_WIDTH(16), .LEN_WIDTH(16), .SPACE_WIDTH(2), .MEM_READ_LATENCY(1)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave),
      .o_cmd(o_cmd), .o_bytes_remaining(o_bytes_remaining),
      .o_busy(o_busy), .o_rx_overflow(o_rx_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  sp;
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   int          ovf_n = 0;
   int          exp_nrd = 0;
   wr_t         wr_log[$];
   int          wr_cyc[$];
   logic [17:0] rd_log[$];
   logic [7:0]  tx_log[$];
   logic [7:0]  cmd_bytes[$];
   logic [7:0]  exp_tx[$];
   wr_t         exp_wr[$];
   bit [7:0]    ref_mem[int];
   bit [7:0]    mem[0:262143];
   logic [7:0]  mem_rdata = 8'h00;

   // memory with one cycle of read latency
   always @(posedge clk) begin
      if (bus.o_mem_en && bus.o_mem_rw)  mem_rdata <= mem[{bus.o_mem_space, bus.o_mem_address}];
      if (bus.o_mem_en && !bus.o_mem_rw) mem[{bus.o_mem_space, bus.o_mem_address}] <= bus.o_mem_data;
   end
   assign bus.i_mem_data = mem_rdata;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // passive monitor: logs accesses/tx, checks the output protocol rules
   initial begin
      bit         hold = 1'b0;
      logic [7:0] held = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (bus.o_mem_en && !bus.o_mem_rw) begin
               wr_log.push_back({bus.o_mem_space, bus.o_mem_address, bus.o_mem_data});
               wr_cyc.push_back(cyc);
            end
            if (bus.o_mem_en && bus.o_mem_rw) rd_log.push_back({bus.o_mem_space, bus.o_mem_address});
            if (bus.o_tx_dv && bus.i_tx_ready) tx_log.push_back(bus.o_tx_byte);
            if (o_rx_overflow) ovf_n++;
            if (hold) begin
               chk("tx_hold_dv", {31'd0, bus.o_tx_dv}, 32'd1);
               chk("tx_hold_byte", {24'd0, bus.o_tx_byte}, {24'd0, held});
            end
            hold = bus.o_tx_dv && !bus.i_tx_ready;
            held = bus.o_tx_byte;
            if (!bus.o_tx_dv) chk("tx_byte_idle", {24'd0, bus.o_tx_byte}, 32'd0);
            if (!bus.o_mem_en) chk("addr_idle", {16'd0, bus.o_mem_address}, 32'd0);
            if (!(bus.o_mem_en && !bus.o_mem_rw)) chk("wdata_idle", {24'd0, bus.o_mem_data}, 32'd0);
         end
      end
   end

   // tx_ready: 0 always ready, 1 random, 2 ready only after 5 low cycles per byte
   initial begin
      int age = 0;
      bus.i_tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bus.o_tx_dv) age++; else age = 0;
         case (rdy_mode)
            0:       bus.i_tx_ready = 1'b1;
            1:       bus.i_tx_ready = ($urandom_range(0, 2) == 0);
            default: bus.i_tx_ready = (age > 5);
         endcase
      end
   end

   function automatic bit [7:0] ref_rd(input int k);
      return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
   endfunction

   // command-level model: what a command byte list must produce
   task automatic model_cmd();
      logic [3:0]  op;
      logic [1:0]  sp;
      logic [15:0] a, n, ai;
      logic [7:0]  d;
      op = cmd_bytes[0][3:0];
      sp = cmd_bytes[0][5:4];
      exp_tx.delete();
      exp_wr.delete();
      exp_nrd = 0;
      case (op)
         4'd1: exp_tx.push_back(cmd_bytes[1]);
         4'd5: begin exp_tx.push_back(8'd16); exp_tx.push_back(8'd16); end
         4'd2, 4'd3, 4'd4: begin
            a = {cmd_bytes[1], cmd_bytes[2]};
            n = {cmd_bytes[3], cmd_bytes[4]};
            if (op == 4'd3) exp_nrd = int'(n);
            for (int i = 0; i < int'(n); i++) begin
               ai = a + 16'(i);
               if (op == 4'd3) begin
                  exp_tx.push_back(ref_rd(int'({sp, ai})));
               end else begin
                  d = (op == 4'd2) ? cmd_bytes[5+i] : cmd_bytes[5];
                  ref_mem[int'({sp, ai})] = d;
                  exp_wr.push_back({sp, ai, d});
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic clear_logs();
      wr_log.delete(); wr_cyc.delete(); rd_log.delete(); tx_log.delete();
      ovf_n = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_rx_byte = b;
      bus.i_rx_dv   = 1'b1;
      @(posedge clk); #1;
      bus.i_rx_dv   = 1'b0;
      bus.i_rx_byte = 8'h00;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (o_busy && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      if (o_busy) chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_cmd(input int mode, input int gap, input string nm);
      clear_logs();
      rdy_mode = mode;
      foreach (cmd_bytes[i]) begin
         send_byte(cmd_bytes[i]);
         repeat ($urandom_range(0, gap)) @(posedge clk);
         #1;
      end
      wait_idle(nm);
   endtask

   task automatic compare_logs(input string nm);
      chk({nm, "_ntx"}, tx_log.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
         chk({nm, "_tx"}, {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
      chk({nm, "_nwr"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         chk({nm, "_wr"}, {6'd0, wr_log[i]}, {6'd0, exp_wr[i]});
      chk({nm, "_nrd"}, rd_log.size(), exp_nrd);
      chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({nm, "_cmd"}, {24'd0, o_cmd}, 32'd0);
      chk({nm, "_rem"}, {16'd0, o_bytes_remaining}, 32'd0);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_tx_dv"}, {31'd0, bus.o_tx_dv}, 32'd0);
      chk({nm, "_tx_byte"}, {24'd0, bus.o_tx_byte}, 32'd0);
      chk({nm, "_mem_en"}, {31'd0, bus.o_mem_en}, 32'd0);
      chk({nm, "_mem_rw"}, {31'd0, bus.o_mem_rw}, 32'd1);
      chk({nm, "_space"}, {30'd0, bus.o_mem_space}, 32'd0);
      chk({nm, "_addr"}, {16'd0, bus.o_mem_address}, 32'd0);
      chk({nm, "_wdata"}, {24'd0, bus.o_mem_data}, 32'd0);
      chk({nm, "_cmd"}, {24'd0, o_cmd}, 32'd0);
      chk({nm, "_rem"}, {16'd0, o_bytes_remaining}, 32'd0);
      chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({nm, "_ovf"}, {31'd0, o_rx_overflow}, 32'd0);
   endtask

   typedef struct {
      logic [63:0] b;
      int          nb;
      logic [31:0] tx;
      int          ntx;
      int          nwr;
      int          nrd;
      int          mode;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int          k, nrd0, ntx0;
      logic [3:0]  op;
      logic [15:0] a, n;
      bus.i_rx_dv   = 1'b0;
      bus.i_rx_byte = 8'h00;

      vecs[0] = '{64'h015A_0000_0000_0000, 2, 32'h5A00_0000, 1, 0, 0, 0}; // echo
      vecs[1] = '{64'h1202_0000_03AA_BBCC, 8, 32'h0,         0, 3, 0, 0}; // write space 1
      vecs[2] = '{64'h1302_0000_0300_0000, 5, 32'hAABB_CC00, 3, 0, 3, 1}; // read it back
      vecs[3] = '{64'h0F00_0000_0000_0000, 1, 32'h0,         0, 0, 0, 0}; // unknown opcode
      vecs[4] = '{64'h01C3_0000_0000_0000, 2, 32'hC300_0000, 1, 0, 0, 0}; // echo after it
      vecs[5] = '{64'h0312_3400_0000_0000, 5, 32'h0,         0, 0, 0, 0}; // read, length 0
      vecs[6] = '{64'h0500_0000_0000_0000, 1, 32'h1010_0000, 2, 0, 0, 1}; // info
      vecs[7] = '{64'hC900_0000_0000_0000, 1, 32'h0,         0, 0, 0, 0}; // opcode 9, high bits set
      vecs[8] = '{64'h2400_2000_0000_0000, 5, 32'h0,         0, 0, 0, 0}; // fill, length 0

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[v]) begin
         cmd_bytes.delete();
         for (int i = 0; i < vecs[v].nb; i++) cmd_bytes.push_back(vecs[v].b[63-8*i -: 8]);
         model_cmd();
         run_cmd(vecs[v].mode, 0, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_ntx", v), tx_log.size(), vecs[v].ntx);
         for (int i = 0; i < vecs[v].ntx && i < tx_log.size(); i++)
            chk($sformatf("vec%0d_tx%0d", v, i), {24'd0, tx_log[i]}, {24'd0, vecs[v].tx[31-8*i -: 8]});
         chk($sformatf("vec%0d_nwr", v), wr_log.size(), vecs[v].nwr);
         chk($sformatf("vec%0d_nrd", v), rd_log.size(), vecs[v].nrd);
         for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk($sformatf("vec%0d_wr%0d", v, i), {6'd0, wr_log[i]}, {6'd0, exp_wr[i]});
         chk($sformatf("vec%0d_busy", v), {31'd0, o_busy}, 32'd0);
         chk($sformatf("vec%0d_cmd", v), {24'd0, o_cmd}, 32'd0);
      end

      // a NOP shows its command byte for exactly one cycle
      send_byte(8'h0F);
      chk("nop_cmd_latched", {24'd0, o_cmd}, 32'h0F);
      chk("nop_busy", {31'd0, o_busy}, 32'd0);
      @(posedge clk); #1;
      chk("nop_cmd_cleared", {24'd0, o_cmd}, 32'd0);

      // read across the address wrap with heavy backpressure
      cmd_bytes = '{8'h02, 8'hFF, 8'hFE, 8'h00, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13};
      model_cmd();
      run_cmd(0, 0, "preload");
      compare_logs("preload");
      cmd_bytes = '{8'h03, 8'hFF, 8'hFE, 8'h00, 8'h04};
      model_cmd();
      run_cmd(2, 0, "rd_wrap");
      compare_logs("rd_wrap");
      chk("rd_wrap_ntx", tx_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < tx_log.size(); i++)
         chk("rd_wrap_byte", {24'd0, tx_log[i]}, 32'h10 + i);
      if (rd_log.size() == 4) begin
         chk("rd_wrap_a0", {14'd0, rd_log[0]}, 32'h0FFFE);
         chk("rd_wrap_a1", {14'd0, rd_log[1]}, 32'h0FFFF);
         chk("rd_wrap_a2", {14'd0, rd_log[2]}, 32'h00000);
         chk("rd_wrap_a3", {14'd0, rd_log[3]}, 32'h00001);
      end

      // fill with a byte injected mid-run
      cmd_bytes = '{8'h04, 8'h00, 8'h10, 8'h00, 8'h05, 8'hEE};
      model_cmd();
      clear_logs();
      rdy_mode = 0;
      foreach (cmd_bytes[i]) send_byte(cmd_bytes[i]);
      send_byte(8'h77);
      wait_idle("fill");
      compare_logs("fill");
      chk("fill_ovf", ovf_n, 32'd1);
      for (int i = 1; i < wr_cyc.size(); i++)
         chk("fill_back_to_back", wr_cyc[i] - wr_cyc[0], i);

      // reset in the middle of a 4-byte read
      clear_logs();
      rdy_mode = 2;
      cmd_bytes = '{8'h03, 8'hFF, 8'hFE, 8'h00, 8'h04};
      foreach (cmd_bytes[i]) send_byte(cmd_bytes[i]);
      k = 0;
      while (tx_log.size() < 2 && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      chk("rst_mid_two_bytes", tx_log.size(), 32'd2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      nrd0 = rd_log.size();
      ntx0 = tx_log.size();
      repeat (20) @(posedge clk);
      #1;
      chk("rst_mid_no_reads", rd_log.size(), nrd0);
      chk("rst_mid_no_tx", tx_log.size(), ntx0);
      chk("rst_mid_no_writes", wr_log.size(), 32'd0);
      chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
      cmd_bytes = '{8'h05};
      model_cmd();
      run_cmd(0, 0, "info_after_rst");
      compare_logs("info_after_rst");

      // random commands against the model
      for (int t = 0; t < 60; t++) begin
         k = $urandom_range(0, 9);
         case (k)
            0:       op = 4'd0;
            1:       op = 4'd1;
            2, 3:    op = 4'd2;
            4, 5:    op = 4'd3;
            6, 7:    op = 4'd4;
            8:       op = 4'd5;
            default: op = 4'($urandom_range(6, 15));
         endcase
         cmd_bytes.delete();
         cmd_bytes.push_back({2'($urandom), 2'($urandom), op});
         if (op == 4'd1) cmd_bytes.push_back(8'($urandom));
         if (op == 4'd2 || op == 4'd3 || op == 4'd4) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            n = 16'($urandom_range(0, 6));
            cmd_bytes.push_back(a[15:8]);
            cmd_bytes.push_back(a[7:0]);
            cmd_bytes.push_back(n[15:8]);
            cmd_bytes.push_back(n[7:0]);
            if (op == 4'd2) for (int i = 0; i < int'(n); i++) cmd_bytes.push_back(8'($urandom));
            if (op == 4'd4 && n != 16'd0) cmd_bytes.push_back(8'($urandom));
         end
         model_cmd();
         run_cmd(int'($urandom_range(0, 1)), 2, $sformatf("rand%0d", t));
         compare_logs($sformatf("rand%0d", t));
         chk($sformatf("rand%0d_ovf", t), ovf_n, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
